// File: rtl/load_mem_issue_if.sv
// Bundle of the load-queue, memory-request and writeback signals around load_mem_issue.
// The master modport is the issue block's view; slave is the surrounding pipeline and memory.
interface load_mem_issue_if #(
  parameter int TAG_W = 4
) ();
  logic             lq_valid;
  logic [63:0]      lq_addr;
  logic [5:0]       lq_dest_reg;
  logic             lq_pop;

  logic [1:0]       mem_command;
  logic [63:0]      mem_addr;
  logic [TAG_W-1:0] mem_response;
  logic [TAG_W-1:0] mem_tag;
  logic [63:0]      mem_data;

  logic             wb_valid;
  logic [5:0]       wb_dest_reg;
  logic [63:0]      wb_data;
  logic             wb_ready;

  modport master (
    input  lq_valid, lq_addr, lq_dest_reg,
    output lq_pop,
    output mem_command, mem_addr,
    input  mem_response, mem_tag, mem_data,
    output wb_valid, wb_dest_reg, wb_data,
    input  wb_ready
  );

  modport slave (
    output lq_valid, lq_addr, lq_dest_reg,
    input  lq_pop,
    input  mem_command, mem_addr,
    output mem_response, mem_tag, mem_data,
    input  wb_valid, wb_dest_reg, wb_data,
    output wb_ready
  );
endinterface

// File: rtl/load_mem_issue.sv
// Issues loads from the load-queue head to memory, tracks them in a circular load buffer,
// captures out-of-order tagged returns and writes results back strictly in allocation order.
module load_mem_issue #(
  parameter int LB_DEPTH = 4,
  parameter int TAG_W    = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  load_mem_issue_if.master     bus
);

  localparam int PTR_W = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  typedef enum logic [1:0] {
    ENTRY_IDLE = 2'd0,
    ENTRY_WAIT = 2'd1,
    ENTRY_DONE = 2'd2
  } entry_state_t;

  entry_state_t     state_q [LB_DEPTH];
  entry_state_t     state_n [LB_DEPTH];
  logic [TAG_W-1:0] tag_q   [LB_DEPTH];
  logic [TAG_W-1:0] tag_n   [LB_DEPTH];
  logic [5:0]       dest_q  [LB_DEPTH];
  logic [5:0]       dest_n  [LB_DEPTH];
  logic [63:0]      data_q  [LB_DEPTH];
  logic [63:0]      data_n  [LB_DEPTH];
  logic [PTR_W-1:0] head_q, head_n;
  logic [PTR_W-1:0] tail_q, tail_n;

  logic full;
  logic issue;
  logic grant;
  logic wb_fire;

  // Full looks only at registered state, so a head freed this cycle cannot admit a new load.
  always_comb begin
    full = 1'b1;
    for (int i = 0; i < LB_DEPTH; i++) begin
      if (state_q[i] == ENTRY_IDLE) full = 1'b0;
    end
  end

  assign issue   = bus.lq_valid & ~full & ~flush;
  assign grant   = issue & (bus.mem_response != '0);
  assign wb_fire = bus.wb_valid & bus.wb_ready;

  assign bus.mem_command = issue ? 2'd1 : 2'd0;
  assign bus.mem_addr    = issue ? bus.lq_addr : 64'd0;
  assign bus.lq_pop      = grant;

  assign bus.wb_valid    = (state_q[head_q] == ENTRY_DONE);
  assign bus.wb_dest_reg = dest_q[head_q];
  assign bus.wb_data     = data_q[head_q];

  // Allocation hits an IDLE tail, capture hits WAIT entries and writeback hits the DONE head,
  // so all three can update the buffer in the same cycle without colliding.
  always_comb begin
    state_n = state_q;
    tag_n   = tag_q;
    dest_n  = dest_q;
    data_n  = data_q;
    head_n  = head_q;
    tail_n  = tail_q;

    if (grant) begin
      state_n[tail_q] = ENTRY_WAIT;
      tag_n[tail_q]   = bus.mem_response;
      dest_n[tail_q]  = bus.lq_dest_reg;
      tail_n          = tail_q + 1'b1;
    end

    for (int i = 0; i < LB_DEPTH; i++) begin
      if ((bus.mem_tag != '0) && (state_q[i] == ENTRY_WAIT) && (tag_q[i] == bus.mem_tag)) begin
        state_n[i] = ENTRY_DONE;
        data_n[i]  = bus.mem_data;
      end
    end

    if (wb_fire) begin
      state_n[head_q] = ENTRY_IDLE;
      head_n          = head_q + 1'b1;
    end

    if (flush) begin
      for (int i = 0; i < LB_DEPTH; i++) begin
        state_n[i] = ENTRY_IDLE;
      end
      head_n = '0;
      tail_n = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LB_DEPTH; i++) begin
        state_q[i] <= ENTRY_IDLE;
        tag_q[i]   <= '0;
        dest_q[i]  <= '0;
        data_q[i]  <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
    end else begin
      state_q <= state_n;
      tag_q   <= tag_n;
      dest_q  <= dest_n;
      data_q  <= data_n;
      head_q  <= head_n;
      tail_q  <= tail_n;
    end
  end

endmodule

// File: tb/tb_load_mem_issue.sv
// Bench for load_mem_issue: directed scenarios plus random traffic, all checked against
// an in-order queue model of outstanding loads.
module tb_load_mem_issue;

  localparam int LB_DEPTH = 4;
  localparam int TAG_W    = 4;

  logic clock = 1'b0;
  logic reset;
  logic flush;

  load_mem_issue_if #(.TAG_W(TAG_W)) bus ();

  load_mem_issue #(.LB_DEPTH(LB_DEPTH), .TAG_W(TAG_W)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [5:0]       dest;
    bit               done;
    logic [63:0]      data;
  } load_t;

  // Outstanding loads, oldest first; writeback always comes from the front.
  load_t model_q[$];
  bit    model_live = 1'b0;
  int    check_count = 0;
  int    error_count = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [TAG_W-1:0] freeTag();
    logic [TAG_W-1:0] free_list[$];
    bit used;
    for (int v = 1; v < (1 << TAG_W); v++) begin
      used = 1'b0;
      foreach (model_q[i]) if (model_q[i].tag == v) used = 1'b1;
      if (!used) free_list.push_back(TAG_W'(v));
    end
    return free_list[$urandom_range(free_list.size() - 1)];
  endfunction

  function automatic logic [TAG_W-1:0] waitingTag(input bit oldest);
    logic [TAG_W-1:0] wait_list[$];
    foreach (model_q[i]) if (!model_q[i].done) wait_list.push_back(model_q[i].tag);
    if (wait_list.size() == 0) return '0;
    if (oldest) return wait_list[0];
    return wait_list[$urandom_range(wait_list.size() - 1)];
  endfunction

  // One clock cycle: drive at the falling edge, check outputs, then advance the model at the rising edge.
  task automatic applyStimulus(input bit rst, input bit fl, input bit lqv, input logic [63:0] addr,
                               input logic [5:0] dest, input logic [TAG_W-1:0] resp,
                               input logic [TAG_W-1:0] mtag, input logic [63:0] mdata, input bit wbr);
    bit exp_issue, exp_pop, exp_wb, found;
    @(negedge clock);
    reset            = rst;
    flush            = fl;
    bus.lq_valid     = lqv;
    bus.lq_addr      = addr;
    bus.lq_dest_reg  = dest;
    bus.mem_response = resp;
    bus.mem_tag      = mtag;
    bus.mem_data     = mdata;
    bus.wb_ready     = wbr;
    #1;
    exp_issue = lqv && (model_q.size() < LB_DEPTH) && !fl;
    exp_pop   = exp_issue && (resp != 0);
    exp_wb    = (model_q.size() > 0) && model_q[0].done;
    if (model_live) begin
      checkOutput("mem_command", 64'(bus.mem_command), exp_issue ? 64'd1 : 64'd0);
      checkOutput("mem_addr", bus.mem_addr, exp_issue ? addr : 64'd0);
      checkOutput("lq_pop", 64'(bus.lq_pop), 64'(exp_pop));
      checkOutput("wb_valid", 64'(bus.wb_valid), 64'(exp_wb));
      if (exp_wb) begin
        checkOutput("wb_dest_reg", 64'(bus.wb_dest_reg), 64'(model_q[0].dest));
        checkOutput("wb_data", bus.wb_data, model_q[0].data);
      end
    end
    @(posedge clock);
    if (rst || fl) begin
      model_q.delete();
      if (rst) model_live = 1'b1;
    end else begin
      found = 1'b0;
      if (mtag != 0) begin
        foreach (model_q[i]) begin
          if (!found && !model_q[i].done && model_q[i].tag == mtag) begin
            model_q[i].done = 1'b1;
            model_q[i].data = mdata;
            found = 1'b1;
          end
        end
      end
      if (exp_wb && wbr) void'(model_q.pop_front());
      if (exp_pop) model_q.push_back('{tag: resp, dest: dest, done: 1'b0, data: 64'd0});
    end
  endtask

  task automatic idle(input int n, input bit wbr);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 64'd0, 6'd0, '0, '0, 64'd0, wbr);
  endtask

  initial begin
    logic [TAG_W-1:0] t1, t2, rtag;

    applyStimulus(1, 0, 0, 64'd0, 6'd0, '0, '0, 64'd0, 0);
    applyStimulus(1, 0, 0, 64'd0, 6'd0, '0, '0, 64'd0, 0);
    applyStimulus(0, 0, 0, 64'd0, 6'd0, '0, '0, 64'd0, 0);

    // Single load, return two cycles later, written back with ready high.
    applyStimulus(0, 0, 1, 64'h100, 6'd5, 4'd3, '0, 64'd0, 1);
    idle(1, 1);
    applyStimulus(0, 0, 0, 64'd0, 6'd0, '0, 4'd3, 64'hABCD, 1);
    idle(3, 1);

    // Memory rejects three times, then grants tag 7.
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 1, 64'h200, 6'd9, '0, '0, 64'd0, 1);
    applyStimulus(0, 0, 1, 64'h200, 6'd9, 4'd7, '0, 64'd0, 1);
    idle(1, 1);
    applyStimulus(0, 0, 0, 64'd0, 6'd0, '0, 4'd7, 64'h77, 1);
    idle(2, 1);

    // Out-of-order returns must still write back in allocation order.
    for (int k = 0; k < 3; k++)
      applyStimulus(0, 0, 1, 64'h300 + 64'(k * 8), 6'(10 + k), 4'(k + 1), '0, 64'd0, 1);
    applyStimulus(0, 0, 0, 64'd0, 6'd0, '0, 4'd3, 64'h3333, 1);
    applyStimulus(0, 0, 0, 64'd0, 6'd0, '0, 4'd1, 64'h1111, 1);
    applyStimulus(0, 0, 0, 64'd0, 6'd0, '0, 4'd2, 64'h2222, 1);
    idle(4, 1);

    // Fill the buffer, stall on full, then stream loads so the pointers wrap several times.
    for (int k = 0; k < 5; k++)
      applyStimulus(0, 0, 1, 64'h400 + 64'(k), 6'(20 + k), freeTag(), '0, 64'd0, 1);
    for (int k = 0; k < 40; k++) begin
      rtag = (k % 2 == 0) ? waitingTag(1) : '0;
      applyStimulus(0, 0, 1, 64'h500 + 64'(k), 6'(k), freeTag(), rtag, 64'($urandom), 1);
    end
    for (int k = 0; k < 8; k++) applyStimulus(0, 0, 0, 64'd0, 6'd0, '0, waitingTag(1), 64'($urandom), 1);

    // Flush with a coincident return; late returns of the squashed tags are ignored.
    t1 = freeTag();
    applyStimulus(0, 0, 1, 64'h600, 6'd30, t1, '0, 64'd0, 1);
    t2 = freeTag();
    applyStimulus(0, 0, 1, 64'h608, 6'd31, t2, '0, 64'd0, 1);
    applyStimulus(0, 1, 1, 64'h610, 6'd32, 4'd9, t1, 64'hDEAD, 1);
    applyStimulus(0, 0, 0, 64'd0, 6'd0, '0, t1, 64'hBEEF, 1);
    applyStimulus(0, 0, 0, 64'd0, 6'd0, '0, t2, 64'hF00D, 1);
    idle(2, 1);

    // Backpressured writeback stays stable, then reset clears everything.
    applyStimulus(0, 0, 1, 64'h700, 6'd40, 4'd5, '0, 64'd0, 0);
    applyStimulus(0, 0, 1, 64'h708, 6'd41, 4'd6, 4'd5, 64'h5555, 0);
    applyStimulus(0, 0, 0, 64'd0, 6'd0, '0, 4'd6, 64'h6666, 0);
    idle(5, 0);
    applyStimulus(1, 0, 0, 64'd0, 6'd0, '0, '0, 64'd0, 0);
    idle(3, 1);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      bit rst_r, fl_r, lqv_r, wbr_r;
      logic [TAG_W-1:0] resp_r, mtag_r;
      int sel;
      rst_r  = ($urandom_range(199) == 0);
      fl_r   = ($urandom_range(49) == 0);
      lqv_r  = ($urandom_range(9) < 7);
      wbr_r  = ($urandom_range(9) < 7);
      resp_r = ($urandom_range(3) == 0) ? '0 : freeTag();
      sel    = $urandom_range(9);
      if (sel < 5)      mtag_r = waitingTag(0);
      else if (sel < 6) mtag_r = TAG_W'($urandom);
      else              mtag_r = '0;
      applyStimulus(rst_r, fl_r, lqv_r, {$urandom, $urandom}, 6'($urandom), resp_r,
                    mtag_r, {$urandom, $urandom}, wbr_r);
    end

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/load_mem_issue.md
LOAD_MEM_ISSUE -- requirements
Module: load_mem_issue

Interface
REQ-001 Parameter: LB_DEPTH, default 4, number of outstanding-load buffer entries; a power of 2, at least 2.
REQ-002 Parameter: TAG_W, default 4, memory tag width; tag value 0 means "no tag".
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 lq_valid  input  1  load-queue head entry is valid.
REQ-006 lq_addr  input  64  load-queue head effective address.
REQ-007 lq_dest_reg  input  6  load-queue head destination physical register.
REQ-008 lq_pop  output  1  pops the load-queue head this cycle.
REQ-009 flush  input  1  squashes all in-flight loads.
REQ-010 mem_command  output  2  memory command: 0 = NONE, 1 = LOAD.
REQ-011 mem_addr  output  64  memory request address.
REQ-012 mem_response  input  TAG_W  tag accepting this cycle's request; 0 = rejected.
REQ-013 mem_tag  input  TAG_W  tag of returning data; 0 = no return.
REQ-014 mem_data  input  64  returning load data, valid when mem_tag != 0.
REQ-015 wb_valid  output  1  writeback entry is presented.
REQ-016 wb_dest_reg  output  6  writeback destination register.
REQ-017 wb_data  output  64  writeback data.
REQ-018 wb_ready  input  1  writeback consumer accepts this cycle.

Function
REQ-019 The block SHALL hold an LB_DEPTH circular buffer with head/tail pointers; each entry holds state (IDLE, WAIT, DONE), tag, dest_reg and data.
REQ-020 full SHALL be computed from registered state: all entries non-IDLE.
REQ-021 Issue condition SHALL be lq_valid & !full & !flush; when true, mem_command=LOAD and mem_addr=lq_addr, combinationally in the same cycle; otherwise mem_command=NONE and mem_addr=0.
REQ-022 On issue with mem_response != 0: lq_pop=1; the tail entry becomes WAIT with tag=mem_response and dest_reg=lq_dest_reg; tail increments modulo LB_DEPTH.
REQ-023 On issue with mem_response == 0: lq_pop=0 and no state change; the request retries in the next cycle.
REQ-024 lq_pop SHALL never be asserted when issue is false.
REQ-025 Each cycle with mem_tag != 0: the single WAIT entry whose tag equals mem_tag becomes DONE and captures mem_data; a nonmatching tag is ignored.
REQ-026 A tag match SHALL be against registered state only; a tag returned in the same cycle it is granted is not matched.
REQ-027 wb_valid SHALL be 1 iff the head entry is DONE, with wb_dest_reg and wb_data taken from the head entry; writeback is strictly in allocation order.
REQ-028 When wb_valid & wb_ready: the head entry becomes IDLE and head increments modulo LB_DEPTH.
REQ-029 When wb_valid & !wb_ready: the outputs SHALL hold stable, and younger DONE entries wait.
REQ-030 Allocation, tag capture and writeback to distinct entries in one cycle SHALL all take effect.
REQ-031 If full, no issue occurs even if the head is freed in that cycle.
REQ-032 flush SHALL take priority over everything: next state is all entries IDLE with head=tail=0; no issue, no pop, and a capture in that cycle is discarded.
REQ-033 wb_valid SHALL be 0 in the cycle after flush.
REQ-034 After flush, late mem_tag returns for squashed loads SHALL be ignored, because they match no WAIT entry.

Reset
REQ-035 On reset the block SHALL set all entries IDLE with tag=0, dest_reg=0 and data=0, and head=tail=0.
REQ-036 In the cycle after reset deasserts: wb_valid=0, lq_pop=0, and mem_command=NONE unless lq_valid=1.
REQ-037 Reset asserted mid-operation SHALL discard all in-flight state identically to REQ-035; reset has priority over flush.

Verification
REQ-038 Single load: lq_valid=1, lq_addr=0x100, lq_dest_reg=5, mem_response=3 -> same cycle mem_command=1, mem_addr=0x100, lq_pop=1; two cycles later mem_tag=3, mem_data=0xABCD -> next cycle wb_valid=1, wb_dest_reg=5, wb_data=0xABCD; with wb_ready=1 -> wb_valid=0 in the following cycle.
REQ-039 Rejection: mem_response=0 for 3 cycles, then 7 -> mem_command=1 for 4 cycles; lq_pop=1 only in the 4th cycle; exactly one entry WAIT with tag=7.
REQ-040 Out-of-order return: issue tags 1,2,3 for dest 10,11,12; return 3, then 1, then 2, with wb_ready=1 -> writebacks occur in order 10,11,12; dest 10 appears the cycle after tag 1 returns.
REQ-041 Full/wrap: issue 4 loads with no returns -> 5th cycle lq_pop=0 and mem_command=0; return the head tag and accept its writeback -> issue resumes next cycle into entry 0 after tail wraps; run 12 loads to exercise wrap 3 times.
REQ-042 Flush: 2 loads WAIT, flush=1 with mem_tag equal to one of them in the same cycle -> next cycle wb_valid=0 and head=tail=0; later returns of both tags produce no wb_valid.
REQ-043 Backpressure plus reset: head DONE with wb_ready=0 for 5 cycles -> wb_dest_reg and wb_data stable; assert reset -> next cycle wb_valid=0 and all entries IDLE.
